// File: rtl/hls_dlmon_pkg.sv
// Shared types and width helpers for the HLS dataflow deadlock monitor.
package hls_dlmon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DETECTED = 2'd2
    } dlmon_state_t;

    // Sub-instance ports keep one bit even when no sub-instances are monitored.
    function automatic int sub_w(input int n_sub);
        return (n_sub > 0) ? n_sub : 1;
    endfunction

    // SRC_W = N_AXIS + N_SUB, never below one bit.
    function automatic int src_w(input int n_axis, input int n_sub);
        return ((n_axis + n_sub) > 0) ? (n_axis + n_sub) : 1;
    endfunction

endpackage

// File: rtl/hls_dlmon_cand.sv
// Combinational block-candidate former: stream stalls OR a fully stuck sub-instance set.
module hls_dlmon_cand
    import hls_dlmon_pkg::*;
#(
    parameter int N_AXIS = 1,
    parameter int N_SUB  = 0
) (
    input  logic [N_AXIS-1:0]              axis_block_sigs,
    input  logic [sub_w(N_SUB)-1:0]        inst_idle_sigs,
    input  logic [sub_w(N_SUB)-1:0]        inst_block_sigs,
    output logic                           cand,
    output logic [src_w(N_AXIS,N_SUB)-1:0] src
);

    logic sub_term;

    generate
        if (N_SUB > 0) begin : g_sub
            // Every sub is parked (idle or blocked) and at least one is actually blocked.
            assign sub_term = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
            assign src      = {inst_block_sigs, axis_block_sigs};
        end else begin : g_nosub
            logic unused_sub;
            assign unused_sub = ^{inst_idle_sigs, inst_block_sigs};
            assign sub_term   = 1'b0;
            assign src        = axis_block_sigs;
        end
    endgenerate

    assign cand = (|axis_block_sigs) | sub_term;

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// Deadlock monitor for one HLS dataflow instance: persistence filter, sticky mode,
// source snapshot and saturating detection counter. All outputs are registered.
module hls_deadlock_param_monitor
    import hls_dlmon_pkg::*;
#(
    parameter int N_AXIS    = 1,
    parameter int N_SUB     = 0,
    parameter int THRESHOLD = 1,
    parameter int CNT_W     = 16,
    parameter int STICKY    = 0,
    parameter int EVT_W     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [N_AXIS-1:0]              axis_block_sigs,
    input  logic [sub_w(N_SUB)-1:0]        inst_idle_sigs,
    input  logic [sub_w(N_SUB)-1:0]        inst_block_sigs,
    output logic                           block,
    output logic [src_w(N_AXIS,N_SUB)-1:0] block_src,
    output logic [CNT_W-1:0]               persist_cnt,
    output logic [EVT_W-1:0]               evt_cnt
);

    localparam int SRC_W = src_w(N_AXIS, N_SUB);
    localparam logic [CNT_W-1:0] TH_FULL = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] TH_LAST = CNT_W'(THRESHOLD - 1);

    dlmon_state_t     state;
    logic             cand;
    logic [SRC_W-1:0] src;

    hls_dlmon_cand #(
        .N_AXIS (N_AXIS),
        .N_SUB  (N_SUB)
    ) u_cand (
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .cand            (cand),
        .src             (src)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            block       <= 1'b0;
            block_src   <= '0;
            persist_cnt <= '0;
            evt_cnt     <= '0;
        end else if (clear) begin
            state       <= IDLE;
            block       <= 1'b0;
            block_src   <= '0;
            persist_cnt <= '0;
            evt_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && cand) begin
                        persist_cnt <= CNT_W'(1);
                        if (THRESHOLD == 1) begin
                            state     <= DETECTED;
                            block     <= 1'b1;
                            block_src <= src;
                            if (evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end else begin
                        persist_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (!cand || !enable) begin
                        state       <= IDLE;
                        persist_cnt <= '0;
                    end else if (persist_cnt == TH_LAST) begin
                        state       <= DETECTED;
                        persist_cnt <= TH_FULL;
                        block       <= 1'b1;
                        block_src   <= src;
                        if (evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;
                    end else begin
                        persist_cnt <= persist_cnt + 1'b1;
                    end
                end
                DETECTED: begin
                    // Sticky mode parks here until clear; snapshot stays frozen either way.
                    if (STICKY == 0 && (!cand || !enable)) begin
                        state       <= IDLE;
                        block       <= 1'b0;
                        persist_cnt <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    block       <= 1'b0;
                    persist_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Directed bench: four monitor configurations driven with hand-computed vectors.
module tb_hls_deadlock_param_monitor;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: 1 stream, no subs, threshold 1, 2-bit event counter
    logic       r_en = 1'b1, r_clr = 1'b0, r_axis = 1'b0, r_blk;
    logic [0:0] r_src;
    logic [15:0] r_pc;
    logic [1:0] r_evt;
    hls_deadlock_param_monitor #(.N_AXIS(1), .N_SUB(0), .THRESHOLD(1), .STICKY(0), .EVT_W(2)) u_ref (
        .clock(clock), .reset(reset), .enable(r_en), .clear(r_clr),
        .axis_block_sigs(r_axis), .inst_idle_sigs(1'b0), .inst_block_sigs(1'b0),
        .block(r_blk), .block_src(r_src), .persist_cnt(r_pc), .evt_cnt(r_evt));

    // Threshold 8, four streams
    logic       t_en = 1'b1, t_clr = 1'b0, t_blk;
    logic [3:0] t_axis = '0, t_src;
    logic [15:0] t_pc;
    logic [7:0] t_evt;
    hls_deadlock_param_monitor #(.N_AXIS(4), .N_SUB(0), .THRESHOLD(8), .STICKY(0)) u_th8 (
        .clock(clock), .reset(reset), .enable(t_en), .clear(t_clr),
        .axis_block_sigs(t_axis), .inst_idle_sigs(1'b0), .inst_block_sigs(1'b0),
        .block(t_blk), .block_src(t_src), .persist_cnt(t_pc), .evt_cnt(t_evt));

    // Three sub-instances, threshold 1
    logic       s_en = 1'b1, s_clr = 1'b0, s_axis = 1'b0, s_blk;
    logic [2:0] s_idle = '0, s_bsig = '0;
    logic [3:0] s_src;
    logic [15:0] s_pc;
    logic [7:0] s_evt;
    hls_deadlock_param_monitor #(.N_AXIS(1), .N_SUB(3), .THRESHOLD(1), .STICKY(0)) u_sub (
        .clock(clock), .reset(reset), .enable(s_en), .clear(s_clr),
        .axis_block_sigs(s_axis), .inst_idle_sigs(s_idle), .inst_block_sigs(s_bsig),
        .block(s_blk), .block_src(s_src), .persist_cnt(s_pc), .evt_cnt(s_evt));

    // Sticky, threshold 2
    logic       k_en = 1'b1, k_clr = 1'b0, k_axis = 1'b0, k_blk;
    logic [0:0] k_src;
    logic [15:0] k_pc;
    logic [7:0] k_evt;
    hls_deadlock_param_monitor #(.N_AXIS(1), .N_SUB(0), .THRESHOLD(2), .STICKY(1)) u_stk (
        .clock(clock), .reset(reset), .enable(k_en), .clear(k_clr),
        .axis_block_sigs(k_axis), .inst_idle_sigs(1'b0), .inst_block_sigs(1'b0),
        .block(k_blk), .block_src(k_src), .persist_cnt(k_pc), .evt_cnt(k_evt));

    initial begin
        tick();
        tick();
        chk("rst_blk", 32'(r_blk), 0);
        chk("rst_evt", 32'(r_evt), 0);
        chk("rst_pc",  32'(t_pc),  0);
        reset = 1'b0;

        // Reference: one-cycle pulse
        r_axis = 1'b1; tick();
        chk("ref_blk_hi", 32'(r_blk), 1);
        chk("ref_evt1",   32'(r_evt), 1);
        chk("ref_pc1",    32'(r_pc),  1);
        r_axis = 1'b0; tick();
        chk("ref_blk_lo", 32'(r_blk), 0);
        chk("ref_pc0",    32'(r_pc),  0);
        for (int i = 0; i < 4; i++) begin
            r_axis = 1'b1; tick();
            r_axis = 1'b0; tick();
        end
        chk("ref_evt_sat", 32'(r_evt), 3);

        // Sub-instance term
        s_idle = 3'b110; s_bsig = 3'b001; tick();
        chk("sub_blk_hi", 32'(s_blk), 1);
        chk("sub_src",    32'(s_src), 32'b0010);
        s_idle = 3'b100; tick();
        chk("sub_blk_lo", 32'(s_blk), 0);
        tick();
        chk("sub_no_det", 32'(s_blk), 0);
        s_idle = 3'b111; s_bsig = 3'b000; tick();
        chk("sub_allidle", 32'(s_blk), 0);

        // Sticky
        k_axis = 1'b1; tick();
        chk("stk_pc1",  32'(k_pc),  1);
        chk("stk_blk0", 32'(k_blk), 0);
        tick();
        chk("stk_blk1", 32'(k_blk), 1);
        chk("stk_pc2",  32'(k_pc),  2);
        k_axis = 1'b0; tick();
        chk("stk_hold", 32'(k_blk), 1);
        k_en = 1'b0; tick();
        chk("stk_en0",  32'(k_blk), 1);
        k_en = 1'b1; k_axis = 1'b1; k_clr = 1'b1; tick();
        chk("stk_clr_blk", 32'(k_blk), 0);
        chk("stk_clr_evt", 32'(k_evt), 0);
        chk("stk_clr_pc",  32'(k_pc),  0);
        k_clr = 1'b0; tick();
        chk("stk_restart", 32'(k_pc), 1);
        tick();
        chk("stk_redet", 32'(k_evt), 1);

        // Threshold 8: 7 cycles is filtered out
        t_axis = 4'b0100;
        repeat (7) tick();
        chk("th_pc7",  32'(t_pc),  7);
        chk("th_blk7", 32'(t_blk), 0);
        t_axis = 4'b0000; tick();
        chk("th_pc_drop", 32'(t_pc),  0);
        chk("th_blk_drop", 32'(t_blk), 0);
        t_axis = 4'b0100;
        repeat (7) tick();
        chk("th_pre8", 32'(t_blk), 0);
        tick();
        chk("th_blk8", 32'(t_blk), 1);
        chk("th_pc8",  32'(t_pc),  8);
        chk("th_src",  32'(t_src), 32'b0100);
        chk("th_evt",  32'(t_evt), 1);
        t_axis = 4'b1100; tick();
        chk("th_src_frz", 32'(t_src), 32'b0100);
        chk("th_pc_sat",  32'(t_pc),  8);
        t_axis = 4'b0000; tick();
        chk("th_release", 32'(t_blk), 0);
        t_en = 1'b0; t_axis = 4'b0001; tick();
        chk("th_en0", 32'(t_pc), 0);
        t_en = 1'b1;

        // Async reset mid-ARMED
        t_axis = 4'b0100;
        repeat (5) tick();
        chk("th_pc5", 32'(t_pc), 5);
        #2 reset = 1'b1;
        #1;
        chk("ar_pc",  32'(t_pc),  0);
        chk("ar_evt", 32'(t_evt), 0);
        chk("ar_src", 32'(t_src), 0);
        chk("ar_blk", 32'(t_blk), 0);
        tick();
        reset = 1'b0; t_axis = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_param_monitor.md
Name: hls_deadlock_param_monitor

Overview:
- Parametrised, next-generation deadlock monitor for one HLS dataflow instance.
- Watches N_AXIS stream-stall flags and N_SUB sub-instance idle/block flags, forming a block candidate each cycle.
- Asserts `block` only after the candidate persists for THRESHOLD consecutive cycles, which filters transient back-pressure.
- Adds a source snapshot, a sticky mode, a software clear and a saturating event counter; it feeds the top-level deadlock aggregator and debug registers.

Parameters:
- N_AXIS, 1, number of AXI-Stream block inputs (>=1).
- N_SUB, 0, number of monitored sub-instances (0 disables the sub-instance term).
- THRESHOLD, 1, consecutive candidate cycles required to declare a block (1..2^CNT_W-1).
- CNT_W, 16, width of the persistence counter.
- STICKY, 0, 1 = `block` held until `clear`; 0 = `block` follows the candidate.
- EVT_W, 8, width of the detection-event counter.

Ports:
- clock, input, 1, single clock; all logic on rising edge.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, monitor armed when 1.
- clear, input, 1, synchronous one-cycle clear of detection state.
- axis_block_sigs, input, N_AXIS, per-stream stall flag.
- inst_idle_sigs, input, max(N_SUB,1), per-sub-instance idle.
- inst_block_sigs, input, max(N_SUB,1), per-sub-instance blocked.
- block, output, 1, deadlock declared.
- block_src, output, N_AXIS+N_SUB (min 1), snapshot of contributing flags at detection: {sub blocks, axis blocks}.
- persist_cnt, output, CNT_W, current consecutive-candidate count.
- evt_cnt, output, EVT_W, number of detections since reset/clear, saturating.

Behaviour:
- Candidate (combinational):
  - cand = |axis_block_sigs OR sub_term.
  - sub_term = (N_SUB>0) AND every sub is (idle|block) AND at least one sub is blocked.
  - Unused inputs are ignored when N_SUB=0.
- Reset (async, any time, including mid-count):
  - state=IDLE, block=0, block_src=0, persist_cnt=0, evt_cnt=0.
- FSM states:
  - IDLE:
    - enable & cand: persist_cnt<=1. If THRESHOLD==1, go to DETECTED on this edge; otherwise go to ARMED.
  - ARMED:
    - !cand or !enable: IDLE, persist_cnt<=0.
    - cand & persist_cnt==THRESHOLD-1: DETECTED, persist_cnt<=THRESHOLD.
    - otherwise persist_cnt++.
  - DETECTED:
    - block=1. block_src is captured on the entry edge from the candidate inputs and frozen while in DETECTED.
    - evt_cnt increments once on entry, saturating at all-ones.
    - STICKY=0: !cand -> IDLE (block drops next edge), persist_cnt<=0.
    - STICKY=1: remain until clear; enable is ignored.
- Latency:
  - `block` rises on the edge where cand has been sampled high for THRESHOLD consecutive edges.
  - THRESHOLD=1 gives one-cycle registered latency (cand high at edge k -> block high after edge k).
- clear (priority below reset, above everything else):
  - Next state IDLE; block, block_src, persist_cnt and evt_cnt all <=0.
  - If clear and cand are both high, clear wins; counting restarts on the following edge.
- enable=0 in IDLE/ARMED forces IDLE. In DETECTED with STICKY=0, enable=0 returns to IDLE.
- persist_cnt saturates at THRESHOLD and never wraps.
- Outputs are registered only; no combinational path from inputs to `block`.

Decomposition:
- Shared package hls_dlmon_pkg holds:
  - State enum {IDLE, ARMED, DETECTED}, 2 bits.
  - Localparam SRC_W = N_AXIS+N_SUB.
- One natural sub-module, hls_dlmon_cand: the combinational candidate/source-vector former, reused by the multi-instance aggregator.
- The counter and FSM stay in the top module.

Test Plan:
- Reference mode: N_AXIS=1, N_SUB=0, THRESHOLD=1, STICKY=0. Pulse axis_block_sigs=1 for 1 cycle -> block high exactly 1 cycle, one edge later; evt_cnt=1.
- THRESHOLD=8, N_AXIS=4:
  - Hold axis[2]=1 for 7 cycles then drop -> block never rises, persist_cnt returns to 0.
  - Hold for 8 cycles -> block rises after the 8th edge, block_src=4'b0100.
- N_SUB=3, idle=3'b110, block=3'b001 -> sub_term=1, detection occurs. With idle=3'b100, block=3'b001 -> no detection.
- STICKY=1:
  - Detect, then drop cand -> block stays 1.
  - Assert clear together with cand -> block=0, evt_cnt=0, next cycle persist_cnt=1.
- Assert reset asynchronously mid-ARMED (persist_cnt=5) -> all outputs 0 immediately, before the next edge.
- evt_cnt with EVT_W=2: 5 detect/release cycles -> evt_cnt saturates at 3.
